// File: rtl/sign_mag_sub_ctrl.sv
// sign_mag_sub_ctrl: byte-serial sign-magnitude add/subtract sequencer.
// One shared 8-bit ripple-borrow slice runs one byte per cycle. If a magnitude
// subtract borrows out, the operands are swapped and a second pass is run.
// Optional build macro: SMSUB_SAT_EN. When defined, an overflowing magnitude
// add saturates to all ones instead of wrapping.
module sign_mag_sub_ctrl #(
    parameter int N_BYTES = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic                   Op,
    input  logic [8*N_BYTES-1:0]   A,
    input  logic [8*N_BYTES-1:0]   B,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [8*N_BYTES-1:0]   Result,
    output logic                   Overflow
);
    localparam int W  = 8 * N_BYTES;
    localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   mag_a, mag_b;   // zero-extended magnitudes
    logic [W-1:0]   diff;           // bytes produced so far in this pass
    logic [W-1:0]   raw;            // diff with the current slice byte merged in
    logic           sign_a;
    logic           do_add;         // signs differ: magnitude add
    logic           borrow;
    logic [IW-1:0]  idx;
    logic           last;
    logic [7:0]     x, y;
    logic [8:0]     slice;          // {borrow_out, diff_byte}
    logic [W-2:0]   mag_fin;
    logic           sign_fin;
    logic           ovf_fin;

    // Shared slice: pick operand bytes (swapped in PASS2, B inverted for add)
    // and produce this cycle's difference byte and borrow out.
    always_comb begin
        last = (idx == IW'(N_BYTES - 1));
        x    = (state == PASS2) ? mag_b[int'(idx)*8 +: 8] : mag_a[int'(idx)*8 +: 8];
        y    = (state == PASS2) ? mag_a[int'(idx)*8 +: 8] : mag_b[int'(idx)*8 +: 8];
        if (do_add) y = ~y;
        slice = {1'b0, x} - {1'b0, y} - {8'd0, borrow};
        raw   = diff;
        raw[int'(idx)*8 +: 8] = slice[7:0];
    end

    // Normalise the completed magnitude: overflow, optional saturation, sign, no -0.
    always_comb begin
        ovf_fin  = do_add & raw[W-1];
        mag_fin  = raw[W-2:0];
`ifdef SMSUB_SAT_EN
        if (ovf_fin) mag_fin = '1;
`endif
        sign_fin = (state == PASS2) ? ~sign_a : sign_a;
        if (mag_fin == '0) sign_fin = 1'b0;
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        In_ready  = (state == IDLE);
        Out_valid = (state == DONE);
        case (state)
            IDLE:  if (In_valid) state_nxt = PASS1;
            PASS1: if (last) state_nxt = (!do_add && slice[8]) ? PASS2 : DONE;
            PASS2: if (last) state_nxt = DONE;
            DONE:  if (Out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-byte accumulation and result latch.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mag_a    <= '0;
            mag_b    <= '0;
            diff     <= '0;
            sign_a   <= 1'b0;
            do_add   <= 1'b0;
            borrow   <= 1'b0;
            idx      <= '0;
            Result   <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (In_valid) begin
                    mag_a  <= {1'b0, A[W-2:0]};
                    mag_b  <= {1'b0, B[W-2:0]};
                    sign_a <= A[W-1];
                    do_add <= A[W-1] ^ B[W-1] ^ Op;
                    borrow <= A[W-1] ^ B[W-1] ^ Op;   // add starts with borrow 1
                    idx    <= '0;
                    diff   <= '0;
                end
                PASS1, PASS2: begin
                    diff   <= raw;
                    borrow <= last ? 1'b0 : slice[8];
                    idx    <= last ? '0 : idx + IW'(1);
                    if (last && (state == PASS2 || do_add || !slice[8])) begin
                        Result   <= {sign_fin, mag_fin};
                        Overflow <= ovf_fin;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sign_mag_sub_ctrl.sv
// Bench for sign_mag_sub_ctrl: directed test-plan vectors plus random operands,
// checked every cycle against an integer-arithmetic reference model.
module tb_sign_mag_sub_ctrl;
    localparam int N    = 2;
    localparam int W    = 8 * N;
    localparam int MAXM = (1 << (W - 1)) - 1;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         In_valid, In_ready, Op, Out_valid, Out_ready, Overflow;
    logic [W-1:0] A, B, Result;

    int           checks = 0;
    int           errors = 0;
    bit           chk_en = 0;
    bit           busy = 0;
    int           edges = 0;
    int           exp_lat = 1;
    logic [W-1:0] exp_res = '0;
    bit           exp_ovf = 0;

    sign_mag_sub_ctrl #(.N_BYTES(N)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
        .Op(Op), .A(A), .B(B), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Result(Result), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: evaluate A op B as signed integers, then encode in sign-magnitude.
    task automatic model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output bit ovf, output int lat);
        int va, vb, r, mag;
        bit s, sa, sb_eff;
        va  = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
        vb  = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
        r   = op ? va + vb : va - vb;
        mag = (r < 0) ? -r : r;
        s   = (r < 0);
        ovf = (mag > MAXM);
        if (ovf) begin
            s = a[W-1];
`ifdef SMSUB_SAT_EN
            mag = MAXM;
`else
            mag = mag % (MAXM + 1);
`endif
        end
        if (mag == 0) s = 0;
        res = W'(mag);
        res[W-1] = s;
        sa     = a[W-1];
        sb_eff = b[W-1] ^ op;
        lat = (sa == sb_eff && a[W-2:0] < b[W-2:0]) ? 2 * N : N;
    endtask

    // Per-cycle compare against the expected handshake and result.
    always @(negedge Clk) begin
        if (Reset_n && chk_en) begin
            chk("in_ready", 32'(In_ready), 32'(!busy));
            chk("out_valid", 32'(Out_valid), 32'(busy && edges >= exp_lat));
            if (busy && edges >= exp_lat) begin
                chk("result", 32'(Result), 32'(exp_res));
                chk("overflow", 32'(Overflow), 32'(exp_ovf));
            end
        end
    end

    task automatic run_op(input bit op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] r;
        bit o;
        int l;
        model(op, a, b, r, o, l);
        @(negedge Clk);
        Op = op; A = a; B = b; In_valid = 1'b1; Out_ready = 1'b0;
        @(posedge Clk);
        exp_res = r; exp_ovf = o; exp_lat = l; edges = 0; busy = 1;
        @(negedge Clk);
        A = W'($urandom); B = W'($urandom); Op = 1'($urandom);
        In_valid = 1'($urandom);   // must be ignored while busy
        for (int i = 0; i < l + hold; i++) begin
            @(posedge Clk);
            edges = i + 1;
        end
        @(negedge Clk);
        In_valid = 1'b0;
        Out_ready = 1'b1;
        @(posedge Clk);
        busy = 0; edges = 0;
    endtask

    task automatic directed(input string name, input bit op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] res_lit,
                            input bit ovf_lit, input int lat_lit, input int hold);
        logic [W-1:0] r;
        bit o;
        int l;
        model(op, a, b, r, o, l);
        chk({name, "_model_res"}, 32'(r), 32'(res_lit));
        chk({name, "_model_ovf"}, 32'(o), 32'(ovf_lit));
        chk({name, "_model_lat"}, 32'(l), 32'(lat_lit));
        run_op(op, a, b, hold);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        Reset_n = 1'b0; In_valid = 1'b0; Op = 1'b0; A = '0; B = '0; Out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(In_ready), 32'd1);
        chk("rst_out_valid", 32'(Out_valid), 32'd0);
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        chk_en = 1;

        directed("sub_5_3", 1'b0, 16'h0005, 16'h0003, 16'h0002, 0, 2, 0);
        directed("sub_3_5", 1'b0, 16'h0003, 16'h0005, 16'h8002, 0, 4, 0);
        directed("sub_5_m3", 1'b0, 16'h0005, 16'h8003, 16'h0008, 0, 2, 0);
        directed("add_xbyte", 1'b1, 16'h8100, 16'h00FF, 16'h8001, 0, 2, 0);
`ifdef SMSUB_SAT_EN
        directed("add_ovf", 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1, 2, 0);
`else
        directed("add_ovf", 1'b1, 16'h7FFF, 16'h0001, 16'h0000, 1, 2, 0);
`endif
        directed("sub_neg0", 1'b0, 16'h8004, 16'h8004, 16'h0000, 0, 2, 0);
        directed("backpress", 1'b0, 16'h0005, 16'h0003, 16'h0002, 0, 2, 10);
        directed("after_bp", 1'b1, 16'h0010, 16'h0020, 16'h0030, 0, 2, 0);

        // Reset pulse while the swapped second pass is running.
        @(negedge Clk);
        Op = 1'b0; A = 16'h0003; B = 16'h0005; In_valid = 1'b1; Out_ready = 1'b0;
        @(posedge Clk);
        exp_res = 16'h8002; exp_ovf = 0; exp_lat = 4; edges = 0; busy = 1;
        @(negedge Clk);
        In_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            edges = i + 1;
        end
        #2;
        Reset_n = 1'b0;
        busy = 0; edges = 0;
        #1;
        chk("midrst_in_ready", 32'(In_ready), 32'd1);
        chk("midrst_out_valid", 32'(Out_valid), 32'd0);
        chk("midrst_result", 32'(Result), 32'd0);
        chk("midrst_overflow", 32'(Overflow), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        directed("post_rst", 1'b0, 16'h0009, 16'h0002, 16'h0007, 0, 2, 0);

        // Random operands with some equal and extreme magnitudes mixed in.
        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb[W-2:0] = ra[W-2:0];
                1: begin ra[W-2:0] = '1; rb[W-2:0] = W'($urandom_range(0, 3)); end
                2: begin ra[W-2:0] = W'($urandom_range(0, 300)); rb[W-2:0] = W'($urandom_range(0, 300)); end
                default: ;
            endcase
            run_op(1'($urandom), ra, rb, $urandom_range(0, 3));
        end

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
